fetch_pc_stage: RTL and testbench
=================================

Name: fetch_pc_stage

Overview:
- IF stage of the 5-stage MIPS pipeline: holds the PC register, issues instruction-memory requests, and loads the IF/ID pipeline register.
- Produces pc_plus_4 for the first jump/branch mux.
- Consumes the final jump/branch/jr mux output as next_pc_in.
- Honours the hazard unit's stall and the branch/jump flush, including a multi-cycle memory handshake.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on a bubble

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
next_pc_in  input  32  next fetch address from the jr mux (final jump/branch mux)
stall_if  input  1  hazard stall (PCWrite=0, IFIDWrite=0)
flush_if_id  input  1  taken branch/jump/jr resolved in ID; kill fetch in flight
imem_req  output  1  instruction-memory request
imem_addr  output  32  request address
imem_rdata  input  32  instruction word, valid with imem_ack
imem_ack  input  1  request completion, same cycle or later
pc_out  output  32  current fetch address
pc_plus_4  output  32  pc_out + 4, to the branch mux
if_id_instr  output  32  IF/ID instruction
if_id_pc_plus_4  output  32  IF/ID PC+4, used for BTA and jal
if_id_valid  output  1  IF/ID holds a real instruction

Behaviour:
- Registers:
  - fetch_addr (drives pc_out and imem_addr)
  - state: FETCH / HOLD / DISCARD
  - hold_instr, redirect_pc
  - IF/ID: instr, pc_plus_4, valid
- Reset, in the cycle rst=1:
  - fetch_addr=RESET_PC, state=FETCH
  - if_id_instr=NOP_INSTR, if_id_pc_plus_4=0, if_id_valid=0
  - hold_instr=0, redirect_pc=0
  - imem_req forced 0 while rst=1
- Reset asserted mid-operation abandons any outstanding request. The memory is required to drop it.
- pc_plus_4 = fetch_addr + 32'd4, combinational, modulo 2^32 (0xFFFFFFFC -> 0x00000000).
- imem_req = 1 in FETCH and DISCARD (rst=0), otherwise 0.
- imem_addr = fetch_addr, held stable while req=1 until ack. imem_ack is ignored when imem_req=0.
- FETCH, evaluated each cycle:
  - flush_if_id=1:
    - IF/ID <= {NOP_INSTR, 0, valid=0}.
    - With ack: fetch_addr <= next_pc_in, stay FETCH.
    - Without ack: redirect_pc <= next_pc_in, go DISCARD.
  - else ack=1, stall_if=0:
    - IF/ID <= {imem_rdata, pc_plus_4, 1}.
    - fetch_addr <= next_pc_in, stay FETCH.
    - Throughput is 1 instr/cycle when ack is tied high.
  - else ack=1, stall_if=1: hold_instr <= imem_rdata; IF/ID and fetch_addr unchanged; go HOLD.
  - else (no ack): IF/ID holds when stall_if=1. When stall_if=0 and no ack, IF/ID <= bubble (valid=0, instr=NOP_INSTR); pc_plus_4 field is don't-care but driven 0.
- HOLD (no request outstanding):
  - flush_if_id=1: IF/ID <= bubble, fetch_addr <= next_pc_in, go FETCH. hold_instr is discarded.
  - else stall_if=0: IF/ID <= {hold_instr, pc_plus_4, 1}, fetch_addr <= next_pc_in, go FETCH.
  - else: all held.
- DISCARD (killed request still outstanding):
  - ack=1: data dropped, fetch_addr <= redirect_pc, go FETCH.
  - A further flush while in DISCARD overwrites redirect_pc with next_pc_in.
  - IF/ID stays bubble.
- Priority: rst > flush_if_id > stall_if > ack.
- IF/ID update latency: an instruction acked at edge N appears on if_id_* after edge N.

Test Plan:
1. RESET_PC=0, ack tied 1, next_pc_in=pc_plus_4, rst 2 cycles -> imem_addr 0x0,0x4,0x8 on consecutive cycles; if_id_pc_plus_4 0x4,0x8,0xC one cycle later; valid=1; req=0 during rst.
2. Fetch at 0x10 returns 0x8C220004 with stall_if=1 for 2 cycles -> req=0 and IF/ID unchanged during stall; after release IF/ID={0x8C220004,0x14,1}; next imem_addr=next_pc_in.
3. Ack with flush_if_id=1, next_pc_in=0x40 -> IF/ID={0x0,0,0}; next cycle imem_addr=0x40, req=1.
4. Request at 0x20, ack delayed 3 cycles, flush with next_pc_in=0x80 in cycle 1 -> req held at 0x20 until ack; ack data never reaches IF/ID; next request at 0x80.
5. RESET_PC=0xFFFFFFFC, ack=1 -> pc_plus_4=0x0, if_id_pc_plus_4=0x0, next fetch 0x0 when next_pc_in=pc_plus_4.
6. rst asserted during DISCARD -> next cycle state FETCH, imem_addr=RESET_PC, if_id_valid=0, late ack for the old request ignored.

Source files
------------

// File: rtl/fetch_pc_stage.sv
// fetch_pc_stage: IF stage of the 5-stage MIPS pipeline.
// Holds the PC register, issues instruction-memory requests with a
// req/ack handshake and loads the IF/ID pipeline register.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   next_pc_in          final jump/branch/jr mux output
//   stall_if            hazard stall (PCWrite=0, IFIDWrite=0)
//   flush_if_id         redirect resolved in ID; kills the fetch in flight
//   imem_req/addr       instruction-memory request
//   imem_rdata/ack      instruction word and completion
//   pc_out, pc_plus_4   current fetch address and its successor
//   if_id_*             IF/ID pipeline register (instr, pc+4, valid)
module fetch_pc_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc_in,
  input  logic        stall_if,
  input  logic        flush_if_id,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus_4,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus_4,
  output logic        if_id_valid
);

  localparam int unsigned XLEN = 32;

  // FETCH: request outstanding; HOLD: instruction parked during a stall;
  // DISCARD: killed request still outstanding, waiting for its ack.
  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   fetch_addr_q, fetch_addr_d;
  logic [XLEN-1:0]   hold_instr_q, hold_instr_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic [XLEN-1:0]   if_id_instr_q, if_id_instr_d;
  logic [XLEN-1:0]   if_id_pc4_q, if_id_pc4_d;
  logic              if_id_valid_q, if_id_valid_d;

  // Wraps modulo 2^32 naturally.
  assign pc_plus_4 = fetch_addr_q + XLEN'(4);

  assign pc_out          = fetch_addr_q;
  assign imem_addr       = fetch_addr_q;
  assign imem_req        = !rst && (state_q == S_FETCH || state_q == S_DISCARD);
  assign if_id_instr     = if_id_instr_q;
  assign if_id_pc_plus_4 = if_id_pc4_q;
  assign if_id_valid     = if_id_valid_q;

  // Next-state and IF/ID load; priority flush > stall > ack.
  always_comb begin
    state_d       = state_q;
    fetch_addr_d  = fetch_addr_q;
    hold_instr_d  = hold_instr_q;
    redirect_pc_d = redirect_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_valid_d = if_id_valid_q;

    case (state_q)
      S_FETCH: begin
        if (flush_if_id) begin
          if_id_instr_d = NOP_INSTR;
          if_id_pc4_d   = '0;
          if_id_valid_d = 1'b0;
          if (imem_ack) begin
            fetch_addr_d = next_pc_in;
          end else begin
            redirect_pc_d = next_pc_in;
            state_d       = S_DISCARD;
          end
        end else if (imem_ack && !stall_if) begin
          if_id_instr_d = imem_rdata;
          if_id_pc4_d   = pc_plus_4;
          if_id_valid_d = 1'b1;
          fetch_addr_d  = next_pc_in;
        end else if (imem_ack) begin
          // Park the returned word; request completes so req drops.
          hold_instr_d = imem_rdata;
          state_d      = S_HOLD;
        end else if (!stall_if) begin
          if_id_instr_d = NOP_INSTR;
          if_id_pc4_d   = '0;
          if_id_valid_d = 1'b0;
        end
      end

      S_HOLD: begin
        if (flush_if_id) begin
          if_id_instr_d = NOP_INSTR;
          if_id_pc4_d   = '0;
          if_id_valid_d = 1'b0;
          fetch_addr_d  = next_pc_in;
          state_d       = S_FETCH;
        end else if (!stall_if) begin
          if_id_instr_d = hold_instr_q;
          if_id_pc4_d   = pc_plus_4;
          if_id_valid_d = 1'b1;
          fetch_addr_d  = next_pc_in;
          state_d       = S_FETCH;
        end
      end

      S_DISCARD: begin
        if_id_instr_d = NOP_INSTR;
        if_id_pc4_d   = '0;
        if_id_valid_d = 1'b0;
        if (flush_if_id) begin
          redirect_pc_d = next_pc_in;
        end
        // The newest redirect wins if a flush coincides with the ack.
        if (imem_ack) begin
          fetch_addr_d = flush_if_id ? next_pc_in : redirect_pc_q;
          state_d      = S_FETCH;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State and pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      fetch_addr_q  <= RESET_PC;
      hold_instr_q  <= '0;
      redirect_pc_q <= '0;
      if_id_instr_q <= NOP_INSTR;
      if_id_pc4_q   <= '0;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_addr_q  <= fetch_addr_d;
      hold_instr_q  <= hold_instr_d;
      redirect_pc_q <= redirect_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Testbench for fetch_pc_stage: scoreboard queues hold expected memory
// handshake addresses and IF/ID entries; a negedge monitor pops and compares.
module tb_fetch_pc_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: RESET_PC = 0
  logic        rst, stall_if, flush_if_id, imem_ack, follow, mem_model;
  logic [31:0] next_pc_tb, rdata_tb, next_pc_in, imem_rdata;
  logic        imem_req, if_id_valid;
  logic [31:0] imem_addr, pc_out, pc_plus_4, if_id_instr, if_id_pc_plus_4;

  assign next_pc_in = follow ? pc_plus_4 : next_pc_tb;
  assign imem_rdata = mem_model ? (32'hA000_0000 | imem_addr) : rdata_tb;

  fetch_pc_stage dut0 (
    .clk(clk), .rst(rst), .next_pc_in(next_pc_in), .stall_if(stall_if),
    .flush_if_id(flush_if_id), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .pc_out(pc_out),
    .pc_plus_4(pc_plus_4), .if_id_instr(if_id_instr),
    .if_id_pc_plus_4(if_id_pc_plus_4), .if_id_valid(if_id_valid)
  );

  // Instance 1: RESET_PC at the top of the address space
  logic        rst1, ack1, req1, valid1;
  logic [31:0] addr1, pc1, pc4_1, instr1, ifpc4_1;

  fetch_pc_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst(rst1), .next_pc_in(pc4_1), .stall_if(1'b0),
    .flush_if_id(1'b0), .imem_req(req1), .imem_addr(addr1),
    .imem_rdata(32'h1111_0000), .imem_ack(ack1), .pc_out(pc1),
    .pc_plus_4(pc4_1), .if_id_instr(instr1),
    .if_id_pc_plus_4(ifpc4_1), .if_id_valid(valid1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] req_q[$];
  logic [63:0] ifid_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: one pop per memory handshake and per new valid IF/ID entry.
  logic [63:0] last_ifid = '0;
  logic        last_v    = 1'b0;
  always @(negedge clk) begin
    logic [31:0] ea;
    logic [63:0] ee;
    logic [63:0] cur;
    if (!rst && imem_req && imem_ack) begin
      n_checks++;
      if (req_q.size() == 0) begin
        n_fail++;
        $display("FAIL req_unexpected: got addr %h expected no handshake", imem_addr);
      end else begin
        ea = req_q.pop_front();
        if (imem_addr !== ea) begin
          n_fail++;
          $display("FAIL req_addr: got %h expected %h", imem_addr, ea);
        end
      end
    end
    cur = {if_id_instr, if_id_pc_plus_4};
    if (if_id_valid === 1'b1 && (!last_v || cur !== last_ifid)) begin
      n_checks++;
      if (ifid_q.size() == 0) begin
        n_fail++;
        $display("FAIL ifid_unexpected: got %h expected no entry", cur);
      end else begin
        ee = ifid_q.pop_front();
        if (cur !== ee) begin
          n_fail++;
          $display("FAIL ifid_entry: got %h expected %h", cur, ee);
        end
      end
    end
    last_ifid = cur;
    last_v    = (if_id_valid === 1'b1);
  end

  initial begin
    rst = 1'b1; stall_if = 1'b0; flush_if_id = 1'b0; imem_ack = 1'b1;
    follow = 1'b1; mem_model = 1'b1; next_pc_tb = '0; rdata_tb = '0;
    rst1 = 1'b1; ack1 = 1'b1;

    // Sequential fetch with ack tied high
    tick();
    chk("req_in_rst_a", 32'(imem_req), 32'd0);
    tick();
    chk("req_in_rst_b", 32'(imem_req), 32'd0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_valid", 32'(if_id_valid), 32'd0);
    chk("rst_instr", if_id_instr, 32'h0);
    chk("rst_ifpc4", if_id_pc_plus_4, 32'h0);
    req_q.push_back(32'h0); req_q.push_back(32'h4); req_q.push_back(32'h8);
    ifid_q.push_back({32'hA000_0000, 32'h4});
    ifid_q.push_back({32'hA000_0004, 32'h8});
    ifid_q.push_back({32'hA000_0008, 32'hC});
    rst = 1'b0;
    tick(); tick(); tick();
    imem_ack = 1'b0;
    chk("seq_addr", imem_addr, 32'hC);
    tick();
    chk("noack_bubble", 32'(if_id_valid), 32'd0);

    // Stall on an acked fetch at 0x10
    req_q.push_back(32'hC);
    ifid_q.push_back({32'hA000_000C, 32'h10});
    imem_ack = 1'b1;
    tick();
    mem_model = 1'b0; rdata_tb = 32'h8C22_0004; stall_if = 1'b1;
    follow = 1'b0; next_pc_tb = 32'h100;
    req_q.push_back(32'h10);
    tick();
    chk("hold_req", 32'(imem_req), 32'd0);
    chk("hold_pc", pc_out, 32'h10);
    tick();
    chk("hold_req2", 32'(imem_req), 32'd0);
    chk("hold_instr", if_id_instr, 32'hA000_000C);
    chk("hold_ifpc4", if_id_pc_plus_4, 32'h10);
    ifid_q.push_back({32'h8C22_0004, 32'h14});
    stall_if = 1'b0; imem_ack = 1'b0;
    tick();
    chk("release_req", 32'(imem_req), 32'd1);
    chk("release_addr", imem_addr, 32'h100);

    // Flush coinciding with ack
    imem_ack = 1'b1; flush_if_id = 1'b1; next_pc_tb = 32'h40; rdata_tb = 32'hDEAD_BEEF;
    req_q.push_back(32'h100);
    tick();
    chk("flush_valid", 32'(if_id_valid), 32'd0);
    chk("flush_instr", if_id_instr, 32'h0);
    chk("flush_ifpc4", if_id_pc_plus_4, 32'h0);
    chk("flush_addr", imem_addr, 32'h40);
    chk("flush_req", 32'(imem_req), 32'd1);
    chk("flush_pc4", pc_plus_4, 32'h44);

    // Flush while request at 0x20 waits three cycles for its ack
    req_q.push_back(32'h40);
    next_pc_tb = 32'h20;
    tick();
    imem_ack = 1'b0; flush_if_id = 1'b1; next_pc_tb = 32'h80;
    tick();
    chk("disc_req", 32'(imem_req), 32'd1);
    chk("disc_addr", imem_addr, 32'h20);
    flush_if_id = 1'b0; next_pc_tb = 32'h1234;
    tick();
    chk("disc_addr2", imem_addr, 32'h20);
    chk("disc_valid", 32'(if_id_valid), 32'd0);
    imem_ack = 1'b1; rdata_tb = 32'hBADB_AD00;
    req_q.push_back(32'h20);
    tick();
    imem_ack = 1'b0;
    chk("disc_redirect", imem_addr, 32'h80);
    chk("disc_req_after", 32'(imem_req), 32'd1);
    chk("disc_dropped", 32'(if_id_valid), 32'd0);

    // Reset during DISCARD
    flush_if_id = 1'b1; next_pc_tb = 32'h200;
    tick();
    flush_if_id = 1'b0;
    chk("disc2_addr", imem_addr, 32'h80);
    rst = 1'b1;
    tick();
    chk("rst_disc_req", 32'(imem_req), 32'd0);
    rst = 1'b0;
    chk("rst_disc_addr", imem_addr, 32'h0);
    chk("rst_disc_valid", 32'(if_id_valid), 32'd0);
    tick();
    chk("rst_disc_hold", imem_addr, 32'h0);
    follow = 1'b1; imem_ack = 1'b1; rdata_tb = 32'h2402_0005;
    req_q.push_back(32'h0);
    ifid_q.push_back({32'h2402_0005, 32'h4});
    tick();
    imem_ack = 1'b0;
    chk("rst_disc_fetch", imem_addr, 32'h4);
    tick();

    // Wrap at the top of the address space
    chk("wrap_rst_pc", pc1, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc4_1, 32'h0);
    rst1 = 1'b0;
    tick();
    chk("wrap_ifpc4", ifpc4_1, 32'h0);
    chk("wrap_valid", 32'(valid1), 32'd1);
    chk("wrap_instr", instr1, 32'h1111_0000);
    chk("wrap_next", pc1, 32'h0);
    tick();
    chk("wrap_ifpc4_b", ifpc4_1, 32'h4);
    chk("wrap_next_b", addr1, 32'h4);

    tick();
    chk("req_q_drained", 32'(req_q.size()), 32'd0);
    chk("ifid_q_drained", 32'(ifid_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
